uart_imem_loader: RTL and testbench

- Boot-time loader in front of the instruction memory of the FPGA system top.
- Receives a framed program image over a UART RX line and writes it word by word into instruction memory.
- Holds the CPU in reset while a load is in progress.
- Releases the CPU once a complete, valid image has been written, so programs no longer have to be poked into memory from the bench.

---
 rtl/uart_imem_loader.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: boot-time loader that receives a framed program image on a
// UART RX line (8N1, LSB first) and writes it word by word into instruction
// memory, holding the CPU in reset until a complete, valid image is loaded.
// Image: 0xA5, count lo, count hi, count x 4 data bytes (little-endian words),
// then an XOR checksum byte when UART_LOADER_CHECKSUM_EN is defined.
// Optional macro: UART_LOADER_CHECKSUM_EN (default build: no checksum byte).
// ADDR_WIDTH is expected to be at most 15 so the count fits the 16-bit field.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  imemWe,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  output logic [31:0]           imemData,
  output logic                  cpuHold,
  output logic                  loadDone,
  output logic                  loadError
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]          HDR_BYTE  = 8'hA5;
  localparam logic [16:0]         MAX_COUNT = 17'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] IDX_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {F_IDLE, F_CNT_LO, F_CNT_HI, F_DATA, F_CSUM, F_DONE} f_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
  // One step of the running image checksum.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Synchroniser and edge-detect history for the asynchronous rx line.
  logic r_rx_meta, r_rx_sync, r_rx_prev;

  // Bit receiver state.
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_byte_valid;
  logic             r_frame_err;

  // Frame state.
  f_state_t              r_f_state;
  logic [7:0]            r_cnt_lo;
  logic [ADDR_WIDTH:0]   r_word_cnt;
  logic [ADDR_WIDTH:0]   r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_word_asm;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_data;
  logic                  r_cpu_hold;
  logic                  r_load_done;
  logic                  r_load_error;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic [15:0]         w_count;
  logic [ADDR_WIDTH:0] w_idx_next;

  assign w_count    = {r_byte, r_cnt_lo};
  assign w_idx_next = r_word_idx + IDX_ONE;

  assign imemWe    = r_imem_we;
  assign imemAddr  = r_imem_addr;
  assign imemData  = r_imem_data;
  assign cpuHold   = r_cpu_hold;
  assign loadDone  = r_load_done;
  assign loadError = r_load_error;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Bit receiver: mid-bit sampling of start, 8 data bits and stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            // A line already back high at mid-start was only a glitch.
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt    <= '0;
            r_byte       <= r_shift;
            r_byte_valid <= r_rx_sync;
            r_frame_err  <= !r_rx_sync;
            r_rx_state   <= RX_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_ONE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
          r_clk_cnt  <= '0;
        end
      endcase
    end
  end

  // Frame parser: header, word count, data words, checksum, status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_state    <= F_IDLE;
      r_cnt_lo     <= 8'd0;
      r_word_cnt   <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= 2'd0;
      r_word_asm   <= 24'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_data  <= 32'd0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      case (r_f_state)
        F_IDLE: begin
          // Line framing errors between images are harmless and ignored.
          if (r_byte_valid && (r_byte == HDR_BYTE)) begin
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_word_idx   <= '0;
            r_byte_idx   <= 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
            r_f_state    <= F_CNT_LO;
          end
        end
        F_CNT_LO: begin
          if (r_frame_err) begin
            r_load_error <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_f_state    <= F_IDLE;
          end else if (r_byte_valid) begin
            r_cnt_lo  <= r_byte;
            r_f_state <= F_CNT_HI;
          end
        end
        F_CNT_HI: begin
          if (r_frame_err || (r_byte_valid && ({1'b0, w_count} > MAX_COUNT))) begin
            r_load_error <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_f_state    <= F_IDLE;
          end else if (r_byte_valid) begin
            r_word_cnt <= w_count[ADDR_WIDTH:0];
            if (w_count == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              r_f_state <= F_CSUM;
`else
              r_f_state <= F_DONE;
`endif
            end else begin
              r_f_state <= F_DATA;
            end
          end
        end
        F_DATA: begin
          if (r_frame_err) begin
            r_load_error <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_f_state    <= F_IDLE;
          end else if (r_byte_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum <= csum_step(r_csum, r_byte);
`endif
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word_asm[7:0]   <= r_byte;
              2'd1: r_word_asm[15:8]  <= r_byte;
              2'd2: r_word_asm[23:16] <= r_byte;
              default: begin
                r_imem_we   <= 1'b1;
                r_imem_addr <= r_word_idx[ADDR_WIDTH-1:0];
                r_imem_data <= {r_byte, r_word_asm};
                r_word_idx  <= w_idx_next;
                if (w_idx_next == r_word_cnt) begin
`ifdef UART_LOADER_CHECKSUM_EN
                  r_f_state <= F_CSUM;
`else
                  r_f_state <= F_DONE;
`endif
                end
              end
            endcase
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        F_CSUM: begin
          if (r_frame_err || (r_byte_valid && (r_byte != r_csum))) begin
            r_load_error <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_f_state    <= F_IDLE;
          end else if (r_byte_valid) begin
            r_f_state <= F_DONE;
          end
        end
`endif
        F_DONE: begin
          r_cpu_hold  <= 1'b0;
          r_load_done <= 1'b1;
          r_f_state   <= F_IDLE;
        end
        default: begin
          r_f_state <= F_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader with a write scoreboard.
// Follows the DUT configuration: with UART_LOADER_CHECKSUM_EN defined the
// images carry a trailing XOR checksum byte, otherwise they do not.
module tb_uart_imem_loader;

  localparam int CPB = 4;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          imemWe;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemData;
  logic          cpuHold;
  logic          loadDone;
  logic          loadError;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_base;
  logic [7:0] csum_m;

  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .imemWe(imemWe), .imemAddr(imemAddr), .imemData(imemData),
    .cpuHold(cpuHold), .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imemWe === 1'b1) begin
      wr_count++;
      checks++;
      assert (exp_addr.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write", imemAddr, imemData);
      end
      if (exp_addr.size() > 0) begin
        chk("wr_addr", 32'(imemAddr), 32'(exp_addr.pop_front()));
        chk("wr_data", imemData, exp_data.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
  endtask

  task automatic start_image(input logic [15:0] count);
    csum_m = 8'd0;
    send_byte(8'hA5, 1'b1);
    send_byte(count[7:0], 1'b1);
    send_byte(count[15:8], 1'b1);
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
    for (int k = 0; k < 4; k++) begin
      send_byte(d[8*k +: 8], 1'b1);
      csum_m = csum_m ^ d[8*k +: 8];
    end
  endtask

  task automatic finish_image(input logic bad);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(csum_m ^ {7'd0, bad}, 1'b1);
`else
    if (bad) idle(1);
`endif
  endtask

  task automatic chk_status(input string tag, input logic hold, input logic done, input logic err);
    chk({tag, "_hold"}, {31'd0, cpuHold}, {31'd0, hold});
    chk({tag, "_done"}, {31'd0, loadDone}, {31'd0, done});
    chk({tag, "_err"}, {31'd0, loadError}, {31'd0, err});
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    idle(3);
    chk("rst_we", {31'd0, imemWe}, 32'd0);
    chk("rst_addr", 32'(imemAddr), 32'd0);
    chk("rst_data", imemData, 32'd0);
    chk_status("rst", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle line: nothing happens.
    idle(200);
    chk_status("idle", 1'b1, 1'b0, 1'b0);
    chk("idle_writes", 32'(wr_count), 32'd0);

    // Good two-word image.
    wr_base = wr_count;
    start_image(16'd2);
    send_word(10'd0, 32'h0010_0093);
    send_word(10'd1, 32'hFFF0_8093);
    finish_image(1'b0);
    idle(20);
    chk_status("good", 1'b0, 1'b1, 1'b0);
    chk("good_writes", 32'(wr_count - wr_base), 32'd2);
    chk("good_addr_hold", 32'(imemAddr), 32'd1);
    chk("good_data_hold", imemData, 32'hFFF0_8093);

    // Same image, corrupted checksum; header must re-assert hold.
    wr_base = wr_count;
    csum_m = 8'd0;
    send_byte(8'hA5, 1'b1);
    idle(8);
    chk_status("rehdr", 1'b1, 1'b0, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(10'd0, 32'h0010_0093);
    send_word(10'd1, 32'hFFF0_8093);
    finish_image(1'b1);
    idle(20);
`ifdef UART_LOADER_CHECKSUM_EN
    chk_status("badsum", 1'b1, 1'b0, 1'b1);
`else
    chk_status("badsum", 1'b0, 1'b1, 1'b0);
`endif
    chk("badsum_writes", 32'(wr_count - wr_base), 32'd2);

    // Stray bytes then an empty image.
    wr_base = wr_count;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    start_image(16'd0);
    finish_image(1'b0);
    idle(20);
    chk_status("empty", 1'b0, 1'b1, 1'b0);
    chk("empty_writes", 32'(wr_count - wr_base), 32'd0);

    // Bad stop bit on the second data byte.
    wr_base = wr_count;
    start_image(16'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(20);
    chk_status("stoperr", 1'b1, 1'b0, 1'b1);
    chk("stoperr_writes", 32'(wr_count - wr_base), 32'd0);

    // One-cycle glitch between header and count must not become a byte.
    wr_base = wr_count;
    csum_m = 8'd0;
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(40);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(10'd0, 32'hCAFE_BABE);
    finish_image(1'b0);
    idle(20);
    chk_status("glitch", 1'b0, 1'b1, 1'b0);
    chk("glitch_writes", 32'(wr_count - wr_base), 32'd1);

    // Count one past memory size.
    wr_base = wr_count;
    start_image(16'h0401);
    idle(12);
    chk_status("toobig", 1'b1, 1'b0, 1'b1);
    chk("toobig_writes", 32'(wr_count - wr_base), 32'd0);

    // Successful load, then reset in the middle of the next word.
    start_image(16'd1);
    send_word(10'd0, 32'h1234_5678);
    finish_image(1'b0);
    idle(20);
    chk_status("preabort", 1'b0, 1'b1, 1'b0);
    wr_base = wr_count;
    start_image(16'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_status("abort", 1'b1, 1'b0, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(20);
    chk_status("postabort", 1'b1, 1'b0, 1'b0);
    chk("abort_writes", 32'(wr_count - wr_base), 32'd0);
    chk("abort_addr", 32'(imemAddr), 32'd0);
    chk("abort_data", imemData, 32'd0);

    chk("sb_empty", 32'(exp_addr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
